lm_sm_sequencer: RTL and testbench

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

---
 rtl/lm_sm_sequencer_pkg.sv | 26 ++
 rtl/lm_sm_sequencer_lsb_first_enc.sv | 18 +
 rtl/lm_sm_sequencer.sv | 150 +++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared processor definitions used by the LM/SM micro-op sequencer:
// multiple-transfer opcodes, sequencer state encoding and small mask helpers.
package lm_sm_sequencer_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEQ  = 1'b1
  } seq_state_e;

  function automatic logic is_multi_op(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

  // True when at least two bits are set: clearing the lowest leaves something.
  function automatic logic multi_bit(input logic [7:0] m);
    return (m & (m - 8'd1)) != 8'd0;
  endfunction

  function automatic logic [7:0] bit_of(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_lsb_first_enc.sv
// Lowest-set-bit priority encoder: picks the next register of an LM/SM list.
module lsb_first_enc (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       any
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/lm_sm_sequencer.sv
// Splits LM/SM instructions into one micro-op per listed register and passes
// every other instruction through unchanged, stalling fetch while it expands.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] ir,
  input  logic        stall_in,
  input  logic        flush,
  output logic        hold_fetch,
  output logic        out_valid,
  output logic [15:0] out_ir,
  output logic [2:0]  out_reg,
  output logic [2:0]  out_offset,
  output logic        out_is_load,
  output logic        first_multiple,
  output logic        last_multiple
);

  seq_state_e  state_q, state_d;
  logic [7:0]  pending_q, pending_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  reg_q, reg_d;
  logic [2:0]  off_q, off_d;
  logic        load_q, load_d;
  logic        first_q, first_d;
  logic        last_q, last_d;

  logic [7:0]  enc_mask;
  logic [2:0]  enc_idx;
  logic        enc_any;

  // One encoder serves both phases: the fresh list in IDLE, the remainder in SEQ.
  assign enc_mask = (state_q == S_SEQ) ? pending_q : ir[7:0];

  lsb_first_enc u_enc (
    .mask (enc_mask),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  assign hold_fetch = (state_q == S_IDLE)
                    ? (in_valid && is_multi_op(ir[15:12]) && multi_bit(ir[7:0]))
                    : multi_bit(pending_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    ir_d      = ir_q;
    reg_d     = reg_q;
    off_d     = off_q;
    load_d    = load_q;
    first_d   = first_q;
    last_d    = last_q;

    if (flush) begin
      state_d   = S_IDLE;
      pending_d = 8'd0;
      cnt_d     = 3'd0;
      valid_d   = 1'b0;
      ir_d      = 16'd0;
      reg_d     = 3'd0;
      off_d     = 3'd0;
      load_d    = 1'b0;
      first_d   = 1'b0;
      last_d    = 1'b0;
    end else if (!stall_in) begin
      unique case (state_q)
        S_IDLE: begin
          pending_d = 8'd0;
          cnt_d     = 3'd0;
          valid_d   = 1'b0;
          ir_d      = 16'd0;
          reg_d     = 3'd0;
          off_d     = 3'd0;
          load_d    = 1'b0;
          first_d   = 1'b0;
          last_d    = 1'b0;
          if (in_valid && !is_multi_op(ir[15:12])) begin
            valid_d = 1'b1;
            ir_d    = ir;
          end else if (in_valid && enc_any) begin
            valid_d   = 1'b1;
            ir_d      = ir;
            reg_d     = enc_idx;
            load_d    = (ir[15:12] == OP_LM);
            first_d   = 1'b1;
            pending_d = ir[7:0] & ~bit_of(enc_idx);
            last_d    = (pending_d == 8'd0);
            cnt_d     = last_d ? 3'd0 : 3'd1;
            state_d   = last_d ? S_IDLE : S_SEQ;
          end
        end
        S_SEQ: begin
          valid_d   = 1'b1;
          reg_d     = enc_idx;
          off_d     = cnt_q;
          first_d   = 1'b0;
          pending_d = pending_q & ~bit_of(enc_idx);
          last_d    = (pending_d == 8'd0);
          cnt_d     = last_d ? 3'd0 : cnt_q + 3'd1;
          state_d   = last_d ? S_IDLE : S_SEQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pending_q <= 8'd0;
      cnt_q     <= 3'd0;
      valid_q   <= 1'b0;
      ir_q      <= 16'd0;
      reg_q     <= 3'd0;
      off_q     <= 3'd0;
      load_q    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      ir_q      <= ir_d;
      reg_q     <= reg_d;
      off_q     <= off_d;
      load_q    <= load_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_ir         = ir_q;
  assign out_reg        = reg_q;
  assign out_offset     = off_q;
  assign out_is_load    = load_q;
  assign first_multiple = first_q;
  assign last_multiple  = last_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: expected micro-ops are queued as each
// cycle's stimulus is driven and compared once the DUT registers its output.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] ir;
  logic        stall_in;
  logic        flush;
  logic        hold_fetch;
  logic        out_valid;
  logic [15:0] out_ir;
  logic [2:0]  out_reg;
  logic [2:0]  out_offset;
  logic        out_is_load;
  logic        first_multiple;
  logic        last_multiple;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        valid;
    logic [15:0] ir;
    logic [2:0]  rg;
    logic [2:0]  off;
    logic        load;
    logic        first;
    logic        last;
  } exp_t;

  exp_t sb[$];

  lm_sm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .ir             (ir),
    .stall_in       (stall_in),
    .flush          (flush),
    .hold_fetch     (hold_fetch),
    .out_valid      (out_valid),
    .out_ir         (out_ir),
    .out_reg        (out_reg),
    .out_offset     (out_offset),
    .out_is_load    (out_is_load),
    .first_multiple (first_multiple),
    .last_multiple  (last_multiple)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [15:0] i, input logic [2:0] r,
                              input logic [2:0] o, input logic ld, input logic f,
                              input logic l);
    exp_t e;
    e.valid = v; e.ir = i; e.rg = r; e.off = o; e.load = ld; e.first = f; e.last = l;
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Payload fields only matter for a valid micro-op; the load flag only for LM/SM.
  task automatic compare(input string tag, input exp_t e);
    check({tag, ".valid"}, 16'(out_valid), 16'(e.valid));
    check({tag, ".first"}, 16'(first_multiple), 16'(e.first));
    check({tag, ".last"}, 16'(last_multiple), 16'(e.last));
    if (e.valid) begin
      check({tag, ".ir"}, out_ir, e.ir);
      check({tag, ".reg"}, 16'(out_reg), 16'(e.rg));
      check({tag, ".offset"}, 16'(out_offset), 16'(e.off));
      if (e.ir[15:13] == 3'b011) check({tag, ".load"}, 16'(out_is_load), 16'(e.load));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 16'(out_valid), 16'd0);
    check({tag, ".ir"}, out_ir, 16'd0);
    check({tag, ".reg"}, 16'(out_reg), 16'd0);
    check({tag, ".offset"}, 16'(out_offset), 16'd0);
    check({tag, ".load"}, 16'(out_is_load), 16'd0);
    check({tag, ".first"}, 16'(first_multiple), 16'd0);
    check({tag, ".last"}, 16'(last_multiple), 16'd0);
  endtask

  // Called at posedge+1: drive, check the combinational hold, queue the
  // expectation, then compare the registered result one edge later.
  task automatic cycle(input string tag, input logic v, input logic [15:0] i,
                       input logic st, input logic fl, input logic exp_hf, input exp_t e);
    in_valid = v; ir = i; stall_in = st; flush = fl;
    #1;
    check({tag, ".hold_fetch"}, 16'(hold_fetch), 16'(exp_hf));
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag, sb.pop_front());
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; ir = 16'h0; stall_in = 1'b0; flush = 1'b0;
    #12;
    check_all_zero("reset");
    check("reset.hold_fetch", 16'(hold_fetch), 16'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // LM R1, list 0xA5: R0,R2,R5,R7; garbage on ir mid-sequence is ignored.
    cycle("lmA5_0", 1, 16'h62A5, 0, 0, 1, mk(1, 16'h62A5, 3'd0, 3'd0, 1, 1, 0));
    cycle("lmA5_1", 1, 16'h62A5, 0, 0, 1, mk(1, 16'h62A5, 3'd2, 3'd1, 1, 0, 0));
    cycle("lmA5_2", 1, 16'h7F00, 0, 0, 1, mk(1, 16'h62A5, 3'd5, 3'd2, 1, 0, 0));
    cycle("lmA5_3", 1, 16'h62A5, 0, 0, 0, mk(1, 16'h62A5, 3'd7, 3'd3, 1, 0, 1));
    cycle("add0",   1, 16'h0123, 0, 0, 0, mk(1, 16'h0123, 3'd0, 3'd0, 0, 0, 0));

    // SM single register: first and last on the same micro-op.
    cycle("sm10",   1, 16'h7410, 0, 0, 0, mk(1, 16'h7410, 3'd4, 3'd0, 0, 1, 1));
    cycle("idle0",  0, 16'h0000, 0, 0, 0, bubble());

    // Empty list is a NOP; the next instruction is taken right away.
    cycle("lm00",   1, 16'h6200, 0, 0, 0, bubble());
    cycle("add1",   1, 16'h1111, 0, 0, 0, mk(1, 16'h1111, 3'd0, 3'd0, 0, 0, 0));

    // LM 0xFF with a two-cycle stall after the second micro-op.
    cycle("lmFF_0", 1, 16'h64FF, 0, 0, 1, mk(1, 16'h64FF, 3'd0, 3'd0, 1, 1, 0));
    cycle("lmFF_1", 1, 16'h64FF, 0, 0, 1, mk(1, 16'h64FF, 3'd1, 3'd1, 1, 0, 0));
    cycle("stall0", 1, 16'h64FF, 1, 0, 1, mk(1, 16'h64FF, 3'd1, 3'd1, 1, 0, 0));
    cycle("stall1", 1, 16'h64FF, 1, 0, 1, mk(1, 16'h64FF, 3'd1, 3'd1, 1, 0, 0));
    for (int k = 2; k < 8; k++) begin
      cycle($sformatf("lmFF_%0d", k), 1, 16'h64FF, 0, 0, (k < 7),
            mk(1, 16'h64FF, 3'(k), 3'(k), 1, 0, (k == 7)));
    end

    // Flush (with stall also high) while the third micro-op of 0x0F is out.
    cycle("lm0F_0", 1, 16'h660F, 0, 0, 1, mk(1, 16'h660F, 3'd0, 3'd0, 1, 1, 0));
    cycle("lm0F_1", 1, 16'h660F, 0, 0, 1, mk(1, 16'h660F, 3'd1, 3'd1, 1, 0, 0));
    cycle("lm0F_2", 1, 16'h660F, 0, 0, 1, mk(1, 16'h660F, 3'd2, 3'd2, 1, 0, 0));
    cycle("flush",  1, 16'h660F, 1, 1, 0, bubble());
    cycle("add2",   1, 16'h2345, 0, 0, 0, mk(1, 16'h2345, 3'd0, 3'd0, 0, 0, 0));

    // Reset mid-sequence of 0xF0 right after R4.
    cycle("lmF0_0", 1, 16'h68F0, 0, 0, 1, mk(1, 16'h68F0, 3'd4, 3'd0, 1, 1, 0));
    reset = 1'b0; in_valid = 1'b0; ir = 16'h0;
    #1;
    check_all_zero("async_rst");
    check("async_rst.hold_fetch", 16'(hold_fetch), 16'd0);
    @(posedge clk); #1;
    check_all_zero("held_rst");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    cycle("post_rst", 0, 16'h0000, 0, 0, 0, bubble());
    cycle("add3",     1, 16'h3456, 0, 0, 0, mk(1, 16'h3456, 3'd0, 3'd0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
